branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- IF-stage branch predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Looked up combinationally with the fetch PC. Produces is_pred_taken / is_pred_hit for IF_ID_CReg_s and the predicted target for the PC_IF_PRED mux leg.
- Trained from EX with the resolved branch/jump outcome. Also flags mispredictions back to the PC-select/flush logic and keeps performance counters.

Parameters:
- BTB_ENTRIES, 64, number of BTB entries; power of 2, minimum 4.
- IDX_W, $clog2(BTB_ENTRIES), index width; derived, not overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- if_pc_i  in  32  fetch PC
- if_pred_hit_o  out  1  valid BTB entry with matching tag
- if_pred_taken_o  out  1  predicted taken
- if_pred_target_o  out  32  predicted target; 0 when not hit
- ex_upd_valid_i  in  1  EX holds a valid, non-flushed instruction
- ex_pc_i  in  32  PC of the EX instruction
- ex_is_br_i  in  1  conditional branch
- ex_is_jp_i  in  1  JAL/JALR
- ex_taken_i  in  1  resolved direction; jumps always 1
- ex_target_i  in  32  resolved target (ALU result)
- ex_pred_taken_i  in  1  prediction carried down the pipe
- ex_pred_target_i  in  32  predicted target carried down the pipe
- ex_mispred_o  out  1  redirect required
- stat_ctrl_cnt_o  out  32  retired branches plus jumps
- stat_mispred_cnt_o  out  32  mispredictions

Behaviour:
- Entry fields: valid; tag = pc[31:IDX_W+2]; target[31:0]; cnt[1:0]. Index = pc[IDX_W+1:2]. pc[1:0] is ignored.
- Reset (synchronous): all valid = 0, all cnt = 2'b01, stat counters = 0. Outputs during and after reset are therefore hit = 0, taken = 0, target = 0, mispred = 0.
- Lookup is combinational, zero latency:
  - hit = valid & tag match.
  - taken = hit & cnt[1].
  - target = hit ? entry.target : 0.
- Update happens at the clock edge when ex_upd_valid_i = 1. Let ctrl = ex_is_br_i | ex_is_jp_i.
  - ctrl, tag hit, branch: cnt saturating +1 if taken, -1 if not taken (limits 00 and 11). If taken, target is overwritten with ex_target_i.
  - ctrl, tag hit, jump: cnt = 11, target = ex_target_i.
  - ctrl, miss, taken: allocate the entry (replacing any occupant) with valid = 1, tag, target = ex_target_i, cnt = 10 for a branch or 11 for a jump.
  - ctrl, miss, not taken: no change.
  - Not ctrl, but ex_pred_taken_i = 1 (alias or stale entry): clear valid of the indexed entry if its tag matches.
- ex_mispred_o is combinational and asserted only when ex_upd_valid_i = 1 and any of the following holds:
  - ctrl & (ex_pred_taken_i != ex_taken_i);
  - ctrl & taken & pred_taken & (ex_pred_target_i != ex_target_i), which covers JALR;
  - !ctrl & ex_pred_taken_i.
- Stat counters, when ex_upd_valid_i = 1:
  - stat_ctrl_cnt_o increments by 1 when ctrl.
  - stat_mispred_cnt_o increments by 1 when ex_mispred_o.
  - Both wrap modulo 2^32.
- Simultaneous lookup and update to the same index in one cycle: the lookup returns the pre-update contents (no bypass). The update is visible from the next cycle.
- Reset asserted mid-operation: reset wins over any update in that cycle.
- Stall/flush gating is the caller's job. The caller must deassert ex_upd_valid_i for bubbles and squashed instructions.
- Storage is a flop array; no SRAM.

Decomposition:
- Shared package:
  - BTB_ENTRIES default;
  - typedef enum for counter states (SNT = 00, WNT = 01, WT = 10, ST = 11);
  - packed struct btb_entry_s {valid, tag, target, cnt};
  - BP update struct {valid, pc, is_br, is_jp, taken, target, pred_taken, pred_target}, usable as an EX-stage port bundle.
- Sub-module: sat_counter2, a pure function or a small module implementing the 2-bit saturating next-state.
- The rest stays in one module.

Test Plan:
- Reset, then lookup at 0x100 → hit = 0, taken = 0, target = 0; both stat counters = 0.
- Update branch pc = 0x100, taken, target = 0x80, pred_taken = 0 → mispred = 1 that cycle. Next-cycle lookup 0x100 → hit = 1, taken = 1, target = 0x80, cnt = 10; stat_mispred = 1, stat_ctrl = 1.
- Two further taken updates to 0x100 → cnt saturates at 11. Then one not-taken → cnt 10, still taken. A second not-taken → cnt 01, taken = 0, hit = 1.
- Aliasing with BTB_ENTRIES = 64: entry for 0x100, then taken JAL update at 0x200 (same index, other tag) → lookup 0x100 hit = 0; lookup 0x200 hit = 1, taken = 1 (cnt = 11).
- Non-ctrl instruction at 0x200 with pred_taken = 1 → mispred = 1; next lookup 0x200 hit = 0.
- Lookup and update of 0x300 in the same cycle (taken, target 0x40) → that cycle hit = 0; the following cycle hit = 1, target = 0x40.

Source files
------------

// File: rtl/branch_target_predictor_pkg.sv
// branch_target_predictor_pkg: shared types and helpers for the BTB predictor
package branch_target_predictor_pkg;
  localparam int DEF_BTB_ENTRIES = 64;
  localparam int TAG_W = 28;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_e;
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    cnt_e             cnt;
  } btb_entry_s;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        is_br;
    logic        is_jp;
    logic        taken;
    logic [31:0] target;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bp_upd_s;
  function automatic logic [TAG_W-1:0] tag_of(logic [31:0] pc, int idx_w);
    return TAG_W'(pc >> (idx_w + 2));
  endfunction
endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// sat_counter2: 2-bit saturating up/down counter next-state
module sat_counter2 (
  input  logic [1:0] cnt,
  input  logic       inc,
  output logic [1:0] nxt
);
  assign nxt = inc ? ((cnt == 2'b11) ? cnt : cnt + 2'd1) : ((cnt == 2'b00) ? cnt : cnt - 2'd1);
endmodule

// File: rtl/branch_target_predictor.sv
// branch_target_predictor: direct-mapped BTB with 2-bit counters, EX-stage training and stats
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int BTB_ENTRIES = DEF_BTB_ENTRIES,
  localparam int IDX_W = $clog2(BTB_ENTRIES)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_pc_i,
  output logic        if_pred_hit_o,
  output logic        if_pred_taken_o,
  output logic [31:0] if_pred_target_o,
  input  logic        ex_upd_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_is_br_i,
  input  logic        ex_is_jp_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        ex_mispred_o,
  output logic [31:0] stat_ctrl_cnt_o,
  output logic [31:0] stat_mispred_cnt_o
);
  btb_entry_s       btb [BTB_ENTRIES];
  bp_upd_s          upd;
  btb_entry_s       if_e, ex_e;
  logic [IDX_W-1:0] if_idx, ex_idx;
  logic             ctrl, ex_hit;
  logic [1:0]       cnt_nxt;
  assign upd = '{valid: ex_upd_valid_i, pc: ex_pc_i, is_br: ex_is_br_i, is_jp: ex_is_jp_i,
                 taken: ex_taken_i, target: ex_target_i, pred_taken: ex_pred_taken_i,
                 pred_target: ex_pred_target_i};
  assign if_idx = if_pc_i[IDX_W+1:2];
  assign if_e = btb[if_idx];
  assign if_pred_hit_o = if_e.valid & (if_e.tag == tag_of(if_pc_i, IDX_W));
  assign if_pred_taken_o = if_pred_hit_o & if_e.cnt[1];
  assign if_pred_target_o = if_pred_hit_o ? if_e.target : 32'd0;
  assign ex_idx = upd.pc[IDX_W+1:2];
  assign ex_e = btb[ex_idx];
  assign ex_hit = ex_e.valid & (ex_e.tag == tag_of(upd.pc, IDX_W));
  assign ctrl = upd.is_br | upd.is_jp;
  assign ex_mispred_o = upd.valid & ((ctrl & ((upd.pred_taken != upd.taken) |
                        (upd.taken & upd.pred_taken & (upd.pred_target != upd.target)))) |
                        (~ctrl & upd.pred_taken));
  sat_counter2 u_cnt (.cnt(ex_e.cnt), .inc(upd.taken), .nxt(cnt_nxt));
  // train the indexed entry from EX and count retired control flow / redirects; reset wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};
      stat_ctrl_cnt_o <= '0;
      stat_mispred_cnt_o <= '0;
    end else if (upd.valid) begin
      if (ctrl & ex_hit) begin
        btb[ex_idx].cnt <= upd.is_jp ? ST : cnt_e'(cnt_nxt);
        if (upd.is_jp | upd.taken) btb[ex_idx].target <= upd.target;
      end else if (ctrl & upd.taken) begin
        btb[ex_idx] <= '{valid: 1'b1, tag: tag_of(upd.pc, IDX_W), target: upd.target,
                         cnt: upd.is_jp ? ST : WT};
      end else if (~ctrl & upd.pred_taken & ex_hit) begin
        btb[ex_idx].valid <= 1'b0;
      end
      if (ctrl) stat_ctrl_cnt_o <= stat_ctrl_cnt_o + 32'd1;
      if (ex_mispred_o) stat_mispred_cnt_o <= stat_mispred_cnt_o + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed vector table plus randomized run against a behavioural BTB model
module tb_branch_target_predictor;
  localparam int N = 64;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_hit, if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_upd_valid, ex_is_br, ex_is_jp, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_mispred;
  logic [31:0] stat_ctrl_cnt, stat_mispred_cnt;
  int checks = 0;
  int errors = 0;

  branch_target_predictor #(.BTB_ENTRIES(N)) dut (
    .clk_i(clk), .rst_i(rst), .if_pc_i(if_pc),
    .if_pred_hit_o(if_pred_hit), .if_pred_taken_o(if_pred_taken), .if_pred_target_o(if_pred_target),
    .ex_upd_valid_i(ex_upd_valid), .ex_pc_i(ex_pc), .ex_is_br_i(ex_is_br), .ex_is_jp_i(ex_is_jp),
    .ex_taken_i(ex_taken), .ex_target_i(ex_target), .ex_pred_taken_i(ex_pred_taken),
    .ex_pred_target_i(ex_pred_target), .ex_mispred_o(ex_mispred),
    .stat_ctrl_cnt_o(stat_ctrl_cnt), .stat_mispred_cnt_o(stat_mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        uv;
    logic [31:0] epc;
    logic        br, jp, tk;
    logic [31:0] tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        hit, taken;
    logic [31:0] target;
    logic        mis;
  } vec_t;
  vec_t v[19];

  bit          mv[N];
  logic [29:0] ml[N];
  logic [31:0] mt[N];
  int          mc[N];
  int unsigned m_ctrl, m_mis;
  logic [31:0] tg[4] = '{32'h40, 32'h44, 32'h80, 32'h500};

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic idle();
    ex_upd_valid = 0; ex_pc = 0; ex_is_br = 0; ex_is_jp = 0; ex_taken = 0;
    ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mv[i] = 0; ml[i] = '0; mt[i] = '0; mc[i] = 1; end
    m_ctrl = 0; m_mis = 0;
  endtask

  function automatic logic [31:0] rpc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  initial begin
    v[0]  = '{32'h100, 0, 0,       0, 0, 0, 0,      0, 0,      0, 0, 0,      0};
    v[1]  = '{32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 0,      0, 0, 0,      1};
    v[2]  = '{32'h100, 0, 0,       0, 0, 0, 0,      0, 0,      1, 1, 32'h80, 0};
    v[3]  = '{32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 1, 1, 32'h80, 0};
    v[4]  = '{32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80, 1, 1, 32'h80, 0};
    v[5]  = '{32'h100, 1, 32'h100, 1, 0, 0, 0,      1, 32'h80, 1, 1, 32'h80, 1};
    v[6]  = '{32'h100, 1, 32'h100, 1, 0, 0, 0,      1, 32'h80, 1, 1, 32'h80, 1};
    v[7]  = '{32'h100, 0, 0,       0, 0, 0, 0,      0, 0,      1, 0, 32'h80, 0};
    v[8]  = '{32'h100, 1, 32'h200, 0, 1, 1, 32'h500,0, 0,      1, 0, 32'h80, 1};
    v[9]  = '{32'h100, 0, 0,       0, 0, 0, 0,      0, 0,      0, 0, 0,      0};
    v[10] = '{32'h200, 0, 0,       0, 0, 0, 0,      0, 0,      1, 1, 32'h500,0};
    v[11] = '{32'h200, 1, 32'h200, 0, 0, 0, 0,      1, 32'h500,1, 1, 32'h500,1};
    v[12] = '{32'h200, 0, 0,       0, 0, 0, 0,      0, 0,      0, 0, 0,      0};
    v[13] = '{32'h300, 1, 32'h300, 1, 0, 1, 32'h40, 0, 0,      0, 0, 0,      1};
    v[14] = '{32'h300, 0, 0,       0, 0, 0, 0,      0, 0,      1, 1, 32'h40, 0};
    v[15] = '{32'h300, 1, 32'h300, 0, 1, 1, 32'h44, 1, 32'h40, 1, 1, 32'h40, 1};
    v[16] = '{32'h300, 0, 0,       0, 0, 0, 0,      0, 0,      1, 1, 32'h44, 0};
    v[17] = '{32'h300, 0, 32'h300, 1, 0, 0, 0,      1, 32'h99, 1, 1, 32'h44, 0};
    v[18] = '{32'h300, 0, 0,       0, 0, 0, 0,      0, 0,      1, 1, 32'h44, 0};

    rst = 1; if_pc = 32'h100; idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #1;
    chk("reset_hit", {31'd0, if_pred_hit}, 0);
    chk("reset_taken", {31'd0, if_pred_taken}, 0);
    chk("reset_target", if_pred_target, 0);
    chk("reset_mispred", {31'd0, ex_mispred}, 0);
    chk("reset_stat_ctrl", stat_ctrl_cnt, 0);
    chk("reset_stat_mis", stat_mispred_cnt, 0);

    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      if_pc = v[i].pc; ex_upd_valid = v[i].uv; ex_pc = v[i].epc; ex_is_br = v[i].br;
      ex_is_jp = v[i].jp; ex_taken = v[i].tk; ex_target = v[i].tgt;
      ex_pred_taken = v[i].ptk; ex_pred_target = v[i].ptgt;
      #1;
      chk($sformatf("v%0d_hit", i), {31'd0, if_pred_hit}, {31'd0, v[i].hit});
      chk($sformatf("v%0d_taken", i), {31'd0, if_pred_taken}, {31'd0, v[i].taken});
      chk($sformatf("v%0d_target", i), if_pred_target, v[i].target);
      chk($sformatf("v%0d_mispred", i), {31'd0, ex_mispred}, {31'd0, v[i].mis});
    end
    @(posedge clk); #1 idle();
    #1;
    chk("dir_stat_ctrl", stat_ctrl_cnt, 8);
    chk("dir_stat_mis", stat_mispred_cnt, 7);

    @(posedge clk); #1;
    rst = 1; ex_upd_valid = 1; ex_pc = 32'h400; ex_is_br = 1; ex_taken = 1; ex_target = 32'h80;
    @(posedge clk); #1;
    rst = 0; idle(); if_pc = 32'h400;
    #1 chk("rstwin_hit_400", {31'd0, if_pred_hit}, 0);
    if_pc = 32'h300;
    #1 chk("rstwin_hit_300", {31'd0, if_pred_hit}, 0);
    chk("rstwin_stat_ctrl", stat_ctrl_cnt, 0);
    chk("rstwin_stat_mis", stat_mispred_cnt, 0);

    model_reset();
    for (int c = 0; c < 3000; c++) begin
      int li, ei, kind;
      bit lh, eh, ctrl, em;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if_pc = rpc();
      ex_upd_valid = ($urandom_range(0, 4) != 0);
      kind = $urandom_range(0, 2);
      ex_is_br = (kind == 0); ex_is_jp = (kind == 1);
      ex_taken = ex_is_jp ? 1'b1 : 1'($urandom_range(0, 1));
      ex_pc = rpc(); ex_target = tg[$urandom_range(0, 3)];
      ex_pred_taken = 1'($urandom_range(0, 1)); ex_pred_target = tg[$urandom_range(0, 3)];
      #1;
      if (rst) begin
        model_reset();
      end else begin
        li = int'(if_pc[31:2] % N);
        lh = mv[li] && ml[li] == if_pc[31:2];
        chk("rnd_hit", {31'd0, if_pred_hit}, {31'd0, lh});
        chk("rnd_taken", {31'd0, if_pred_taken}, {31'd0, lh && mc[li] >= 2});
        chk("rnd_target", if_pred_target, lh ? mt[li] : 32'd0);
        ctrl = ex_is_br || ex_is_jp;
        em = ex_upd_valid && ((ctrl && (ex_pred_taken != ex_taken ||
             (ex_taken && ex_pred_taken && ex_pred_target != ex_target))) || (!ctrl && ex_pred_taken));
        chk("rnd_mispred", {31'd0, ex_mispred}, {31'd0, em});
        chk("rnd_stat_ctrl", stat_ctrl_cnt, m_ctrl);
        chk("rnd_stat_mis", stat_mispred_cnt, m_mis);
        if (ex_upd_valid) begin
          ei = int'(ex_pc[31:2] % N);
          eh = mv[ei] && ml[ei] == ex_pc[31:2];
          if (ctrl && eh) begin
            if (ex_is_jp) mc[ei] = 3;
            else mc[ei] = ex_taken ? (mc[ei] == 3 ? 3 : mc[ei] + 1) : (mc[ei] == 0 ? 0 : mc[ei] - 1);
            if (ex_taken) mt[ei] = ex_target;
          end else if (ctrl && ex_taken) begin
            mv[ei] = 1; ml[ei] = ex_pc[31:2]; mt[ei] = ex_target; mc[ei] = ex_is_jp ? 3 : 2;
          end else if (!ctrl && ex_pred_taken && eh) begin
            mv[ei] = 0;
          end
          if (ctrl) m_ctrl++;
          if (em) m_mis++;
        end
      end
    end
    @(posedge clk); #1 rst = 0; idle();
    #1;
    chk("end_stat_ctrl", stat_ctrl_cnt, m_ctrl);
    chk("end_stat_mis", stat_mispred_cnt, m_mis);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
